// File: rtl/saph_fpu_cvtcmp.sv
`timescale 1ns/1ps
// FP32 compare/min/max/sign/convert unit: fixed LATENCY cycles from accept to q_trig, one request per cycle.
// No backpressure: d_ready is held high from the first edge after reset, and the pipeline never stalls.
module saph_fpu_cvtcmp #(
    parameter int LATENCY = 2,
    parameter int MODE_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [2**MODE_W-1:0]   has_modes,
    output logic                   d_ready,
    input  logic                   d_trig,
    input  logic [MODE_W-1:0]      d_mode,
    input  logic [31:0]            d_lhs,
    input  logic [31:0]            d_rhs,
    output logic                   q_trig,
    output logic [31:0]            q_res
);

    localparam int NRES = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam logic [31:0] FP_ONE = 32'h3F80_0000;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("saph_fpu_cvtcmp: LATENCY must be in 1..8");
    end

    for (genvar g = 0; g < 2**MODE_W; g++) begin : g_modes
        if (g >= 4 && g <= 12) begin : g_on
            assign has_modes[g] = 1'b1;
        end else begin : g_off
            assign has_modes[g] = 1'b0;
        end
    end

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Magnitude with denormals flushed to zero.
    function automatic logic [30:0] fmag(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 31'd0 : x[30:0];
    endfunction

    // Ordered less-than on non-NaN inputs; zero_signed makes -0 < +0 for min/max.
    function automatic logic lt_num(input logic [31:0] a, input logic [31:0] b, input logic zero_signed);
        logic [30:0] ma;
        logic [30:0] mb;
        ma = fmag(a);
        mb = fmag(b);
        if (ma == 31'd0 && mb == 31'd0) return zero_signed && a[31] && !b[31];
        if (a[31] != b[31])             return a[31];
        if (!a[31])                     return ma < mb;
        return ma > mb;
    endfunction

    function automatic logic eq_num(input logic [31:0] a, input logic [31:0] b);
        return (fmag(a) == fmag(b)) && ((a[31] == b[31]) || (fmag(a) == 31'd0));
    endfunction

    function automatic logic [31:0] itof(input logic [31:0] x);
        logic [31:0] m;
        logic [31:0] sh;
        logic [30:0] body;
        logic        rnd;
        int          p;
        if (x == 32'd0) return 32'd0;
        m = x[31] ? -x : x;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) p = i;
        end
        sh   = m << (31 - p);
        rnd  = sh[7] && ((|sh[6:0]) || sh[8]);
        // A mantissa carry out of rounding bumps the exponent naturally.
        body = {8'(127 + p), sh[30:8]} + 31'(rnd);
        return {x[31], body};
    endfunction

    function automatic logic [31:0] ftoi(input logic [31:0] x);
        logic [31:0] sig;
        logic [31:0] m;
        int          e;
        e = int'(x[30:23]);
        if (is_nan(x)) return 32'd0;
        if (e < 127)   return 32'd0;
        if (e >= 158)  return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        sig = {8'd0, 1'b1, x[22:0]};
        m   = (e - 127 >= 23) ? (sig << (e - 150)) : (sig >> (150 - e));
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] calc(input logic [MODE_W-1:0] mode,
                                         input logic [31:0] a, input logic [31:0] b);
        logic any_nan;
        any_nan = is_nan(a) || is_nan(b);
        case (int'(mode))
            4, 5: begin
                if (is_nan(a) && is_nan(b)) return QNAN;
                if (is_nan(a))              return b;
                if (is_nan(b))              return a;
                if (int'(mode) == 4)        return lt_num(b, a, 1'b1) ? b : a;
                return lt_num(a, b, 1'b1) ? b : a;
            end
            6:  return (!any_nan && lt_num(a, b, 1'b0)) ? FP_ONE : 32'd0;
            7:  return (!any_nan && (lt_num(a, b, 1'b0) || eq_num(a, b))) ? FP_ONE : 32'd0;
            8:  return (!any_nan && eq_num(a, b)) ? FP_ONE : 32'd0;
            9:  return itof(a);
            10: return ftoi(a);
            11: return {1'b0, a[30:0]};
            12: return {~a[31], a[30:0]};
            default: return 32'd0;
        endcase
    endfunction

    logic              accept;
    logic              c_vld;
    logic [MODE_W-1:0] c_mode;
    logic [31:0]       c_lhs;
    logic [31:0]       c_rhs;
    logic [31:0]       c_res;
    logic              p_vld [NRES];
    logic [31:0]       p_res [NRES];

    assign accept = d_trig && d_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_ready <= 1'b0;
        else     d_ready <= 1'b1;
    end

    if (LATENCY == 1) begin : g_direct
        assign c_vld  = accept;
        assign c_mode = d_mode;
        assign c_lhs  = d_lhs;
        assign c_rhs  = d_rhs;
    end else begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                c_vld  <= 1'b0;
                c_mode <= '0;
                c_lhs  <= 32'd0;
                c_rhs  <= 32'd0;
            end else begin
                c_vld <= accept;
                if (accept) begin
                    c_mode <= d_mode;
                    c_lhs  <= d_lhs;
                    c_rhs  <= d_rhs;
                end
            end
        end
    end

    assign c_res = calc(c_mode, c_lhs, c_rhs);

    // Result registers only load on a valid so the final stage holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NRES; i++) begin
                p_vld[i] <= 1'b0;
                p_res[i] <= 32'd0;
            end
        end else begin
            p_vld[0] <= c_vld;
            if (c_vld) p_res[0] <= c_res;
            for (int i = 1; i < NRES; i++) begin
                p_vld[i] <= p_vld[i-1];
                if (p_vld[i-1]) p_res[i] <= p_res[i-1];
            end
        end
    end

    assign q_trig = p_vld[NRES-1];
    assign q_res  = p_res[NRES-1];

endmodule

// File: tb/tb_saph_fpu_cvtcmp.sv
`timescale 1ns/1ps
// Directed-vector bench for saph_fpu_cvtcmp: streams of requests checked for exact latency and result.
module tb_saph_fpu_cvtcmp;

    localparam int LATENCY = 2;
    localparam int MODE_W  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] has_modes;
    logic        d_ready;
    logic        d_trig = 1'b0;
    logic [3:0]  d_mode = 4'd0;
    logic [31:0] d_lhs  = 32'd0;
    logic [31:0] d_rhs  = 32'd0;
    logic        q_trig;
    logic [31:0] q_res;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  st_mode [$];
    logic [31:0] st_lhs  [$];
    logic [31:0] st_rhs  [$];
    logic [31:0] st_exp  [$];

    always #5 clk = ~clk;

    saph_fpu_cvtcmp #(.LATENCY(LATENCY), .MODE_W(MODE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .has_modes (has_modes),
        .d_ready   (d_ready),
        .d_trig    (d_trig),
        .d_mode    (d_mode),
        .d_lhs     (d_lhs),
        .d_rhs     (d_rhs),
        .q_trig    (q_trig),
        .q_res     (q_res)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
        st_mode.push_back(m);
        st_lhs.push_back(a);
        st_rhs.push_back(b);
        st_exp.push_back(e);
    endtask

    // Issues the queued vectors on consecutive cycles; each result must appear exactly LATENCY cycles later.
    task automatic run_stream(input string name);
        int n;
        n = st_mode.size();
        for (int k = 0; k < n + LATENCY + 1; k++) begin
            @(negedge clk);
            if (k >= LATENCY && k < n + LATENCY) begin
                check($sformatf("%s[%0d].q_trig", name, k - LATENCY), 32'(q_trig), 32'd1);
                check($sformatf("%s[%0d].q_res", name, k - LATENCY), q_res, st_exp[k - LATENCY]);
            end else begin
                check($sformatf("%s.idle%0d", name, k), 32'(q_trig), 32'd0);
            end
            if (k < n) begin
                d_trig = 1'b1;
                d_mode = st_mode[k];
                d_lhs  = st_lhs[k];
                d_rhs  = st_rhs[k];
            end else begin
                d_trig = 1'b0;
            end
        end
        st_mode.delete();
        st_lhs.delete();
        st_rhs.delete();
        st_exp.delete();
    endtask

    initial begin
        @(negedge clk);
        check("rst.q_trig", 32'(q_trig), 32'd0);
        check("rst.q_res", q_res, 32'd0);
        check("rst.d_ready", 32'(d_ready), 32'd0);
        check("rst.has_modes", 32'(has_modes), 32'h0000_1FF0);
        rst = 1'b0;
        @(negedge clk);
        check("d_ready.up", 32'(d_ready), 32'd1);

        add(4'd4, 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000);
        run_stream("t1_min");

        add(4'd5, 32'h7FC0_0001, 32'h4000_0000, 32'h4000_0000);
        add(4'd8, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0000);
        add(4'd11, 32'hC049_0FDB, 32'h0000_0000, 32'h4049_0FDB);
        run_stream("t2_b2b");

        add(4'd9, 32'h0100_0001, 32'h0, 32'h4B80_0000);
        add(4'd9, 32'h8000_0000, 32'h0, 32'hCF00_0000);
        add(4'd9, 32'h0000_0000, 32'h0, 32'h0000_0000);
        add(4'd9, 32'h7FFF_FFFF, 32'h0, 32'h4F00_0000);
        add(4'd9, 32'hFFFF_FFFF, 32'h0, 32'hBF80_0000);
        add(4'd9, 32'h0000_0007, 32'h0, 32'h40E0_0000);
        run_stream("t3_itof");

        add(4'd10, 32'h4F00_0000, 32'h0, 32'h7FFF_FFFF);
        add(4'd10, 32'hC0B0_0000, 32'h0, 32'hFFFF_FFFB);
        add(4'd10, 32'h7FC0_0000, 32'h0, 32'h0000_0000);
        add(4'd10, 32'hCF00_0000, 32'h0, 32'h8000_0000);
        add(4'd10, 32'h3F00_0000, 32'h0, 32'h0000_0000);
        add(4'd10, 32'h0000_0001, 32'h0, 32'h0000_0000);
        run_stream("t4_ftoi");

        add(4'd4, 32'h7FC0_0000, 32'hFFC0_0001, 32'h7FC0_0000);
        add(4'd4, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000);
        add(4'd5, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        add(4'd5, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
        add(4'd6, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000);
        add(4'd6, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        add(4'd6, 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000);
        add(4'd7, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        add(4'd7, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000);
        add(4'd7, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000);
        add(4'd12, 32'h7FC0_0001, 32'h0, 32'hFFC0_0001);
        add(4'd3, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
        add(4'd11, 32'hFFC0_0001, 32'h0, 32'h7FC0_0001);
        run_stream("misc");

        // In-flight request discarded by reset.
        @(negedge clk);
        d_trig = 1'b1;
        d_mode = 4'd4;
        d_lhs  = 32'h3F80_0000;
        d_rhs  = 32'hBF80_0000;
        @(negedge clk);
        d_trig = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("t5.q_trig", 32'(q_trig), 32'd0);
        check("t5.q_res", q_res, 32'd0);
        check("t5.d_ready", 32'(d_ready), 32'd0);
        check("t5.has_modes", 32'(has_modes), 32'h0000_1FF0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check("t5.d_ready_up", 32'(d_ready), 32'd1);
            check($sformatf("t5.quiet%0d", k), 32'(q_trig), 32'd0);
        end

        // Request held across reset release is ignored while d_ready is still low.
        rst    = 1'b1;
        d_trig = 1'b1;
        d_mode = 4'd5;
        d_lhs  = 32'h4000_0000;
        d_rhs  = 32'h3F80_0000;
        @(negedge clk);
        check("t6.d_ready_lo", 32'(d_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        d_trig = 1'b0;
        check("t6.d_ready_up", 32'(d_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t6.quiet%0d", k), 32'(q_trig), 32'd0);
        end
        check("t6.q_res", q_res, 32'd0);

        add(4'd13, 32'h3F80_0000, 32'h0, 32'h0000_0000);
        add(4'd9, 32'h0000_0001, 32'h0, 32'h3F80_0000);
        run_stream("tail");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
